// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register in-flight write scoreboard with RAW/WAW issue hold
// Optional: REG_SCOREBOARD_FWD_EN (RAW stall only on load-use when ALU forwarding exists)
module reg_scoreboard #(
  parameter  int NUM_REGS     = 32,
  parameter  int MAX_PENDING  = 3,
  parameter  int NUM_WB_PORTS = 2,
  localparam int REG_W        = $clog2(NUM_REGS),
  localparam int CNT_W        = $clog2(MAX_PENDING + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [REG_W-1:0]              issue_rs1,
  input  logic [REG_W-1:0]              issue_rs2,
  input  logic                          issue_use_rs1,
  input  logic                          issue_use_rs2,
  input  logic [REG_W-1:0]              issue_rd,
  input  logic                          issue_wr,
  input  logic                          issue_load,
  input  logic [NUM_WB_PORTS-1:0]       wb_valid,
  input  logic [NUM_WB_PORTS*REG_W-1:0] wb_rd,
  output logic [NUM_REGS-1:0]           pending_vec,
  output logic                          busy,
  output logic                          underflow_err
);

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] ld;
  logic [NUM_REGS-1:0] ld_nxt;
  logic                err;
  logic                err_nxt;
  logic                rs1_haz;
  logic                rs2_haz;
  logic                rd_haz;
  logic                fire;

  // Hazard detection from registered counters only; writebacks this cycle do not unblock
  always_comb begin
`ifdef REG_SCOREBOARD_FWD_EN
    rs1_haz = issue_use_rs1 && (issue_rs1 != '0) && (cnt[issue_rs1] != '0) && ld[issue_rs1];
    rs2_haz = issue_use_rs2 && (issue_rs2 != '0) && (cnt[issue_rs2] != '0) && ld[issue_rs2];
`else
    rs1_haz = issue_use_rs1 && (issue_rs1 != '0) && (cnt[issue_rs1] != '0);
    rs2_haz = issue_use_rs2 && (issue_rs2 != '0) && (cnt[issue_rs2] != '0);
`endif
    rd_haz      = issue_wr && (issue_rd != '0) && (cnt[issue_rd] == CNT_W'(MAX_PENDING));
    issue_ready = !(rs1_haz || rs2_haz || rd_haz) && !flush;
    fire        = issue_valid && issue_ready;
  end

  // Next counter per register: +1 on issuing producer, -1 per retiring port, clamp at zero
  always_comb begin
    err_nxt = err;
    for (int r = 0; r < NUM_REGS; r++) begin
      int  net;
      logic inc;
      inc = fire && issue_wr && (issue_rd == REG_W'(r)) && (r != 0);
      net = int'(cnt[r]) + (inc ? 1 : 0);
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (wb_valid[p] && (wb_rd[p*REG_W +: REG_W] == REG_W'(r)) && (r != 0)) begin
          net = net - 1;
        end
      end
      if (net < 0) begin
        net     = 0;
        err_nxt = 1'b1;
      end
      cnt_nxt[r] = CNT_W'(net);
      ld_nxt[r]  = inc ? issue_load : ld[r];
      if (net == 0) begin
        ld_nxt[r] = 1'b0;
      end
    end
  end

  // Scoreboard state; flush wipes counters and load flags but keeps the sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      ld  <= '0;
      err <= 1'b0;
    end else begin
      err <= err_nxt;
      if (flush) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          cnt[r] <= '0;
        end
        ld <= '0;
      end else begin
        for (int r = 0; r < NUM_REGS; r++) begin
          cnt[r] <= cnt_nxt[r];
        end
        ld <= ld_nxt;
      end
    end
  end

  // Status outputs derived directly from registered counters
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_vec[r] = (cnt[r] != '0);
    end
    busy          = |pending_vec;
    underflow_err = err;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed table, corner sequences and random check of reg_scoreboard
module tb_reg_scoreboard;

  localparam bit FWD = `ifdef REG_SCOREBOARD_FWD_EN 1'b1 `else 1'b0 `endif ;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_use_rs1, issue_use_rs2, issue_wr, issue_load;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic [31:0] pending_vec;
  logic        busy;
  logic        underflow_err;

  reg_scoreboard #(.NUM_REGS(32), .MAX_PENDING(3), .NUM_WB_PORTS(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_load(issue_load),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .pending_vec(pending_vec), .busy(busy), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference: number of outstanding writes per register, youngest-is-load flag, sticky error
  int m_cnt [32];
  bit m_ld  [32];
  bit m_err;

  bit          s_ready;
  logic [31:0] s_pend;
  bit          s_err;

  typedef struct {
    bit fl; bit v;
    logic [4:0] rs1; bit u1; logic [4:0] rs2; bit u2;
    logic [4:0] rd; bit wr; bit ld;
    logic [1:0] wbv; logic [4:0] w0; logic [4:0] w1;
    bit e_ready; logic [31:0] e_pend; bit e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit fl, bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr,
                              bit ld, int wbv, int w0, int w1, bit er, logic [31:0] ep, bit ee);
    vec_t t;
    t.fl = fl; t.v = v; t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2;
    t.rd = 5'(rd); t.wr = wr; t.ld = ld; t.wbv = 2'(wbv); t.w0 = 5'(w0); t.w1 = 5'(w1);
    t.e_ready = er; t.e_pend = ep; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic bit m_ready(input bit fl, input int rs1, input bit u1, input int rs2,
                                 input bit u2, input int rd, input bit wr);
    bit stall;
    stall = 0;
    if (u1 && rs1 != 0 && m_cnt[rs1] > 0 && (!FWD || m_ld[rs1])) stall = 1;
    if (u2 && rs2 != 0 && m_cnt[rs2] > 0 && (!FWD || m_ld[rs2])) stall = 1;
    if (wr && rd != 0 && m_cnt[rd] == 3) stall = 1;
    return !stall && !fl;
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] pv;
    for (int r = 0; r < 32; r++) pv[r] = (m_cnt[r] > 0);
    return pv;
  endfunction

  task automatic m_clear(input bit clr_err);
    for (int r = 0; r < 32; r++) begin
      m_cnt[r] = 0;
      m_ld[r]  = 0;
    end
    if (clr_err) m_err = 0;
  endtask

  // One clock: drive, sample at +1, compare with model, advance model past the edge
  task automatic cyc(input bit fl, input bit v, input int rs1, input bit u1, input int rs2,
                     input bit u2, input int rd, input bit wr, input bit ld, input int wbv,
                     input int w0, input int w1);
    bit er;
    bit fire;
    flush = fl; issue_valid = v;
    issue_rs1 = 5'(rs1); issue_use_rs1 = u1; issue_rs2 = 5'(rs2); issue_use_rs2 = u2;
    issue_rd = 5'(rd); issue_wr = wr; issue_load = ld;
    wb_valid = 2'(wbv); wb_rd = {5'(w1), 5'(w0)};
    #1;
    s_ready = issue_ready; s_pend = pending_vec; s_err = underflow_err;
    er = m_ready(fl, rs1, u1, rs2, u2, rd, wr);
    chk("model ready", {31'b0, issue_ready}, {31'b0, er});
    chk("model pending", pending_vec, m_pend());
    chk("model busy", {31'b0, busy}, {31'b0, (m_pend() != 0)});
    chk("model err", {31'b0, underflow_err}, {31'b0, m_err});
    fire = v && er;
    for (int r = 1; r < 32; r++) begin
      int net;
      bit inc;
      inc = fire && wr && (rd == r);
      net = m_cnt[r] + (inc ? 1 : 0);
      if (wbv[0] && w0 == r) net--;
      if (wbv[1] && w1 == r) net--;
      if (net < 0) begin
        net = 0;
        m_err = 1;
      end
      if (inc) m_ld[r] = ld;
      if (net == 0) m_ld[r] = 0;
      m_cnt[r] = net;
    end
    if (fl) m_clear(0);
    @(negedge clk);
  endtask

  task automatic idle(input int wbv, input int w0, input int w1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, wbv, w0, w1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("async reset pending", pending_vec, 32'h0);
    chk("async reset err", {31'b0, underflow_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    m_clear(1);
  endtask

  initial begin
    m_clear(1);
    reset = 1'b0; flush = 0; issue_valid = 1; issue_rs1 = 0; issue_rs2 = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0; issue_rd = 5'd8; issue_wr = 1; issue_load = 0;
    wb_valid = 0; wb_rd = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset pending", pending_vec, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset err", {31'b0, underflow_err}, 32'h0);
    chk("reset ready", {31'b0, issue_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b1;

    //            fl v rs1 u1 rs2 u2 rd wr ld wbv w0 w1  rdy pend                 err
    tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,1, 0,0,0, 1, 32'h0,               0));
    tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 0,0,0, 0, 32'h20,              0));
    tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 1,5,0, 0, 32'h20,              0));
    tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 0,0,0, 1, 32'h0,               0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1,1, 0,0,0, 1, 32'h0,               0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1,1, 0,0,0, 1, 32'h80,              0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1,1, 0,0,0, 1, 32'h80,              0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1,1, 0,0,0, 0, 32'h80,              0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1,1, 1,7,0, 0, 32'h80,              0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1,1, 0,0,0, 1, 32'h80,              0));
    tbl.push_back(mk(0,1, 0,0, 7,1, 0,0,0, 0,0,0, 0, 32'h80,              0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 3,7,7, 1, 32'h80,              0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1,7,0, 1, 32'h80,              0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0,0,0, 1, 32'h0,               0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 4,1,0, 0,0,0, 1, 32'h0,               0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 4,1,0, 0,0,0, 1, 32'h10,              0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 3,4,4, 1, 32'h10,              0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 3,4,4, 1, 32'h0,               0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0,0,0, 1, 32'h0,               1));
    tbl.push_back(mk(0,1, 0,0, 0,0, 3,1,0, 0,0,0, 1, 32'h0,               1));
    tbl.push_back(mk(0,1, 0,0, 0,0, 3,1,0, 0,0,0, 1, 32'h8,               1));
    tbl.push_back(mk(0,1, 0,0, 0,0, 9,1,0, 0,0,0, 1, 32'h8,               1));
    tbl.push_back(mk(1,1, 0,0, 0,0, 3,1,0, 0,0,0, 0, 32'h208,             1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0,0,0, 1, 32'h0,               1));
    tbl.push_back(mk(0,1, 0,1, 0,1, 0,1,1, 0,0,0, 1, 32'h0,               1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1,0,0, 1, 32'h0,               1));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0,0,0, 1, 32'h0,               1));

    foreach (tbl[i]) begin
      cyc(tbl[i].fl, tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd,
          tbl[i].wr, tbl[i].ld, tbl[i].wbv, tbl[i].w0, tbl[i].w1);
      chk($sformatf("row%0d ready", i), {31'b0, s_ready}, {31'b0, tbl[i].e_ready});
      chk($sformatf("row%0d pending", i), s_pend, tbl[i].e_pend);
      chk($sformatf("row%0d err", i), {31'b0, s_err}, {31'b0, tbl[i].e_err});
    end

    do_reset();
    chk("err cleared by reset", {31'b0, underflow_err}, 32'h0);

    // Forwarding: ALU producer stalls only without forwarding; load producer always stalls
    cyc(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    cyc(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("alu-use ready", {31'b0, s_ready}, {31'b0, FWD});
    idle(1, 6, 0);
    cyc(0, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
    cyc(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("load-use ready", {31'b0, s_ready}, 32'h0);
    cyc(0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0);
    chk("load-use rs2 ready", {31'b0, s_ready}, 32'h0);
    idle(1, 6, 0);
    idle(0, 0, 0);
    chk("fwd seq drained", s_pend, 32'h0);

    for (int it = 0; it < 3000; it++) begin
      if (it % 600 == 599) do_reset();
      cyc(($urandom % 40) == 0, $urandom % 2,
          $urandom % 8, $urandom % 2, $urandom % 8, $urandom % 2,
          $urandom % 8, ($urandom % 4) != 0, $urandom % 2,
          (($urandom % 3) == 0 ? 1 : 0) | (($urandom % 3) == 0 ? 2 : 0),
          $urandom % 8, $urandom % 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
